// File: rtl/ahblite_slave_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ahblite_slave_mux
//  Description : AHB-Lite slave multiplexer for five slave ports. It includes
//                a built-in default slave that returns a two-cycle ERROR for
//                active transfers to unmapped or unpopulated address space.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahblite_slave_mux #(
   parameter int Port0_en = 1,
   parameter int Port1_en = 1,
   parameter int Port2_en = 1,
   parameter int Port3_en = 1,
   parameter int Port4_en = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [1:0]  HTRANS,
   input  logic        P0_HSEL,
   input  logic        P1_HSEL,
   input  logic        P2_HSEL,
   input  logic        P3_HSEL,
   input  logic        P4_HSEL,
   input  logic        P0_HREADYOUT,
   input  logic        P1_HREADYOUT,
   input  logic        P2_HREADYOUT,
   input  logic        P3_HREADYOUT,
   input  logic        P4_HREADYOUT,
   input  logic [31:0] P0_HRDATA,
   input  logic [31:0] P1_HRDATA,
   input  logic [31:0] P2_HRDATA,
   input  logic [31:0] P3_HRDATA,
   input  logic [31:0] P4_HRDATA,
   input  logic        P0_HRESP,
   input  logic        P1_HRESP,
   input  logic        P2_HRESP,
   input  logic        P3_HRESP,
   input  logic        P4_HRESP,
   output logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HRESP
);

   // Data-phase select encoding
   localparam logic [2:0] c_SEL_P0   = 3'd0;
   localparam logic [2:0] c_SEL_P1   = 3'd1;
   localparam logic [2:0] c_SEL_P2   = 3'd2;
   localparam logic [2:0] c_SEL_P3   = 3'd3;
   localparam logic [2:0] c_SEL_P4   = 3'd4;
   localparam logic [2:0] c_SEL_DEF  = 3'd5;
   localparam logic [2:0] c_SEL_NONE = 3'd6;

   // Default-slave FSM encoding
   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_ERR1 = 2'd1;
   localparam logic [1:0] c_ST_ERR2 = 2'd2;

   logic [4:0] w_hsel_eff;
   logic       w_active;
   logic       w_unmapped;
   logic [2:0] w_sel_next;
   logic [2:0] r_dsel;
   logic [1:0] r_state;
   logic [1:0] w_state_next;

   // Unpopulated ports never claim a transfer.
   assign w_hsel_eff = {P4_HSEL & (Port4_en != 0),
                        P3_HSEL & (Port3_en != 0),
                        P2_HSEL & (Port2_en != 0),
                        P1_HSEL & (Port1_en != 0),
                        P0_HSEL & (Port0_en != 0)};

   // NONSEQ or SEQ; IDLE and BUSY never need a response beyond zero-wait OKAY.
   assign w_active   = (HTRANS == 2'b10) || (HTRANS == 2'b11);
   assign w_unmapped = (w_hsel_eff == 5'b0) && w_active;

   // Address-phase decode: the lowest-index selected port wins.
   always_comb begin
      w_sel_next = c_SEL_NONE;
      if (w_hsel_eff[0])      w_sel_next = c_SEL_P0;
      else if (w_hsel_eff[1]) w_sel_next = c_SEL_P1;
      else if (w_hsel_eff[2]) w_sel_next = c_SEL_P2;
      else if (w_hsel_eff[3]) w_sel_next = c_SEL_P3;
      else if (w_hsel_eff[4]) w_sel_next = c_SEL_P4;
      else if (w_unmapped)    w_sel_next = c_SEL_DEF;
   end

   // Data-phase select advances only when the current data phase completes.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)      r_dsel <= c_SEL_NONE;
      else if (HREADY) r_dsel <= w_sel_next;
   end

   // Default-slave FSM state register.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) r_state <= c_ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Default-slave next state; ERR1 always advances since it drives HREADY low itself.
   always_comb begin
      w_state_next = c_ST_IDLE;
      case (r_state)
         c_ST_IDLE: w_state_next = (HREADY && w_unmapped) ? c_ST_ERR1 : c_ST_IDLE;
         c_ST_ERR1: w_state_next = c_ST_ERR2;
         c_ST_ERR2: w_state_next = w_unmapped ? c_ST_ERR1 : c_ST_IDLE;
         default:   w_state_next = c_ST_IDLE;
      endcase
   end

   // Response mux: selected slave, default-slave ERROR pair, or zero-wait OKAY.
   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = 32'h0;
      case (r_dsel)
         c_SEL_P0: begin HREADY = P0_HREADYOUT; HRESP = P0_HRESP; HRDATA = P0_HRDATA; end
         c_SEL_P1: begin HREADY = P1_HREADYOUT; HRESP = P1_HRESP; HRDATA = P1_HRDATA; end
         c_SEL_P2: begin HREADY = P2_HREADYOUT; HRESP = P2_HRESP; HRDATA = P2_HRDATA; end
         c_SEL_P3: begin HREADY = P3_HREADYOUT; HRESP = P3_HRESP; HRDATA = P3_HRDATA; end
         c_SEL_P4: begin HREADY = P4_HREADYOUT; HRESP = P4_HRESP; HRDATA = P4_HRDATA; end
         c_SEL_DEF: begin
            HREADY = (r_state != c_ST_ERR1);
            HRESP  = 1'b1;
         end
         default: begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire
